// File: rtl/neighbor_quality_tx.sv
// rtl/neighbor_quality_tx.sv - neighbor-suppression transmit side: per-channel hit registration and hold-window stretch
module neighbor_quality_tx #(
    parameter int HOLDTIME = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig_stop,
    input  logic       vc,
    input  logic [1:0] sc,
    input  logic       va,
    input  logic [1:0] sa,
    output logic       vcn,
    output logic [1:0] scn,
    output logic       van,
    output logic [1:0] san
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(HOLDTIME - 1);

    // Channel 0 is collision, channel 1 is accelerator.
    state_t     state_q [2];
    state_t     state_d [2];
    logic [2:0] cnt_q   [2];
    logic [2:0] cnt_d   [2];
    logic [1:0] q_q     [2];
    logic [1:0] q_d     [2];
    logic       hit_v   [2];
    logic [1:0] hit_s   [2];

    assign hit_v[0] = vc;
    assign hit_s[0] = sc;
    assign hit_v[1] = va;
    assign hit_s[1] = sa;

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            q_d[ch]     = q_q[ch];
            if (trig_stop) begin
                state_d[ch] = IDLE;
                cnt_d[ch]   = 3'd0;
                q_d[ch]     = 2'd0;
            end else begin
                case (state_q[ch])
                    IDLE: begin
                        if (hit_v[ch]) begin
                            state_d[ch] = HOLD;
                            q_d[ch]     = hit_s[ch];
                            cnt_d[ch]   = CNT_LOAD;
                        end
                    end
                    HOLD: begin
                        if (hit_v[ch]) begin
                            // Keep the best quality seen in this window; any hit re-arms it.
                            if (hit_s[ch] > q_q[ch]) begin
                                q_d[ch] = hit_s[ch];
                            end
                            cnt_d[ch] = CNT_LOAD;
                        end else if (cnt_q[ch] != 3'd0) begin
                            cnt_d[ch] = cnt_q[ch] - 3'd1;
                        end else begin
                            state_d[ch] = IDLE;
                            q_d[ch]     = 2'd0;
                        end
                    end
                    default: begin
                        state_d[ch] = IDLE;
                        cnt_d[ch]   = 3'd0;
                        q_d[ch]     = 2'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (!rst_n) begin
                state_q[ch] <= IDLE;
                cnt_q[ch]   <= 3'd0;
                q_q[ch]     <= 2'd0;
            end else begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
                q_q[ch]     <= q_d[ch];
            end
        end
    end

    // Outputs decode only flop state, so no input reaches an output combinationally.
    assign vcn = (state_q[0] == HOLD);
    assign scn = (state_q[0] == HOLD) ? q_q[0] : 2'd0;
    assign van = (state_q[1] == HOLD);
    assign san = (state_q[1] == HOLD) ? q_q[1] : 2'd0;

endmodule

// File: tb/tb_neighbor_quality_tx.sv
// tb/tb_neighbor_quality_tx.sv - scoreboard bench for neighbor_quality_tx
module tb_neighbor_quality_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig_stop = 1'b0;
    logic       vc = 1'b0;
    logic [1:0] sc = 2'd0;
    logic       va = 1'b0;
    logic [1:0] sa = 2'd0;
    logic       vcn, van, vcn1, van1, vcn7, van7;
    logic [1:0] scn, san, scn1, san1, scn7, san7;

    int errors = 0;
    int checks = 0;

    logic [5:0] sb [$];
    logic [1:0] sb_ht [$];

    always #5 clk = ~clk;

    neighbor_quality_tx #(.HOLDTIME(4)) dut (
        .clk(clk), .rst_n(rst_n), .trig_stop(trig_stop),
        .vc(vc), .sc(sc), .va(va), .sa(sa),
        .vcn(vcn), .scn(scn), .van(van), .san(san)
    );

    neighbor_quality_tx #(.HOLDTIME(1)) dut_ht1 (
        .clk(clk), .rst_n(rst_n), .trig_stop(trig_stop),
        .vc(vc), .sc(sc), .va(va), .sa(sa),
        .vcn(vcn1), .scn(scn1), .van(van1), .san(san1)
    );

    neighbor_quality_tx #(.HOLDTIME(7)) dut_ht7 (
        .clk(clk), .rst_n(rst_n), .trig_stop(trig_stop),
        .vc(vc), .sc(sc), .va(va), .sa(sa),
        .vcn(vcn7), .scn(scn7), .van(van7), .san(san7)
    );

    task automatic drive(input logic r, input logic ts, input logic ivc, input logic [1:0] isc,
                         input logic iva, input logic [1:0] isa);
        rst_n     = r;
        trig_stop = ts;
        vc        = ivc;
        sc        = isc;
        va        = iva;
        sa        = isa;
    endtask

    task automatic test_reset();
        logic [5:0] got, exp;
        for (int c = 0; c < 5; c++) begin
            drive(c >= 3, c == 1, 1'b1 && c < 3, 2'd3, c < 3, 2'd3);
            sb.push_back(6'b0);
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = {vcn, scn, van, san};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset cyc%0d got=%b exp=%b", c + 1, got, exp);
            end
        end
    endtask

    task automatic test_single_pulse();
        logic [5:0] got, exp;
        for (int c = 0; c < 7; c++) begin
            drive(1'b1, 1'b0, c == 0, 2'd2, 1'b0, 2'd0);
            sb.push_back((c < 4) ? 6'b1_10_0_00 : 6'b0);
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = {vcn, scn, van, san};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single_pulse cyc%0d got=%b exp=%b", c + 1, got, exp);
            end
        end
    endtask

    task automatic test_upgrade();
        logic [5:0] got, exp;
        logic [1:0] q;
        for (int c = 0; c < 10; c++) begin
            q = (c == 0) ? 2'd1 : (c == 2) ? 2'd3 : 2'd2;
            drive(1'b1, 1'b0, c == 0 || c == 2 || c == 3, q, 1'b0, 2'd0);
            if (c + 1 <= 2)      sb.push_back(6'b1_01_0_00);
            else if (c + 1 <= 7) sb.push_back(6'b1_11_0_00);
            else                 sb.push_back(6'b0);
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = {vcn, scn, van, san};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL upgrade cyc%0d got=%b exp=%b", c + 1, got, exp);
            end
        end
    endtask

    task automatic test_independent();
        logic [5:0] got, exp;
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, 1'b0, 1'b0, 2'd3, c < 10, 2'd1);
            sb.push_back((c + 1 <= 13) ? 6'b0_00_1_01 : 6'b0);
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = {vcn, scn, van, san};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL independent cyc%0d got=%b exp=%b", c + 1, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] got, exp;
        logic [1:0] qc [6];
        logic       ev_c, ev_a;
        logic [1:0] es_a;
        qc = '{2'd3, 2'd0, 2'd2, 2'd3, 2'd1, 2'd3};
        for (int c = 0; c < 11; c++) begin
            drive(1'b1, 1'b0, c < 6, (c < 6) ? qc[c] : 2'd0, c < 4, 2'(c));
            ev_c = (c + 1 <= 9);
            ev_a = (c + 1 <= 7);
            es_a = !ev_a ? 2'd0 : (c <= 3) ? 2'(c) : 2'd3;
            sb.push_back({ev_c, ev_c ? 2'd3 : 2'd0, ev_a, es_a});
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = {vcn, scn, van, san};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back cyc%0d got=%b exp=%b", c + 1, got, exp);
            end
        end
    endtask

    task automatic test_stop();
        logic [5:0] got, exp;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, c == 2, c == 0 || c == 2, (c == 2) ? 2'd3 : 2'd1,
                  c == 0 || c == 2, (c == 2) ? 2'd3 : 2'd0);
            sb.push_back((c + 1 <= 2) ? 6'b1_01_1_00 : 6'b0);
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = {vcn, scn, van, san};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL trig_stop cyc%0d got=%b exp=%b", c + 1, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] got, exp;
        for (int c = 0; c < 7; c++) begin
            drive(c != 2, 1'b0, c == 0 || c == 2, 2'd3, c == 0, 2'd2);
            sb.push_back((c + 1 <= 2) ? 6'b1_11_1_10 : 6'b0);
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = {vcn, scn, van, san};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid cyc%0d got=%b exp=%b", c + 1, got, exp);
            end
        end
    endtask

    task automatic test_holdtime();
        logic [5:0] got, exp;
        logic [1:0] got_ht, exp_ht;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, c == 0, 2'd1, 1'b0, 2'd0);
            sb.push_back((c + 1 <= 4) ? 6'b1_01_0_00 : 6'b0);
            sb_ht.push_back({c + 1 == 1, c + 1 <= 7});
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = {vcn, scn, van, san};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL holdtime4 cyc%0d got=%b exp=%b", c + 1, got, exp);
            end
            exp_ht = sb_ht.pop_front();
            got_ht = {vcn1, vcn7};
            checks++;
            if (got_ht !== exp_ht) begin
                errors++;
                $display("FAIL holdtime1_7 cyc%0d got={ht1,ht7}=%b exp=%b", c + 1, got_ht, exp_ht);
            end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_single_pulse();
        test_upgrade();
        test_independent();
        test_back_to_back();
        test_stop();
        test_reset_mid();
        test_holdtime();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
